// File: rtl/attack_map_gen.sv
// attack_map_gen: computes the attacked-square bitboard of one side.
// A packed board and attacking colour are captured in IDLE, attacker squares
// are scanned one per cycle and their attack sets are ORed into an
// accumulator. The result is published with a one-cycle strobe.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   board           packed squares, square i at board[i*PIECE_WIDTH +: PIECE_WIDTH]
//                   (MSB = colour, low 3 bits = piece type)
//   color           attacking side (0 white, 1 black)
//   board_valid     capture request, only honoured in IDLE
//   busy            high from capture+1 through the strobe cycle
//   attacked        attacked-square map, held between publishes
//   attacked_valid  one-cycle strobe, attacked valid in the same cycle
//
// Build option: ATTACK_SKIP_EN selects a priority-encoded scan of occupied
// attacker squares instead of the fixed 64-square walk.
module attack_map_gen #(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [SIDE_WIDTH*SIDE_WIDTH*PIECE_WIDTH-1:0] board,
  input  logic                                        color,
  input  logic                                        board_valid,
  output logic                                        busy,
  output logic [SIDE_WIDTH*SIDE_WIDTH-1:0]            attacked,
  output logic                                        attacked_valid
);
  localparam int NSQ = SIDE_WIDTH * SIDE_WIDTH;
  localparam int IW  = $clog2(NSQ);
  localparam int BW  = NSQ * PIECE_WIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic on_board(input int r, input int f);
    return (r >= 0) && (r < SIDE_WIDTH) && (f >= 0) && (f < SIDE_WIDTH);
  endfunction

  function automatic logic [PIECE_WIDTH-1:0] sq_code(input logic [BW-1:0] b, input int s);
    return PIECE_WIDTH'(b >> (s * PIECE_WIDTH));
  endfunction

  // Types 1..6 are real pieces; 0 and 7 count as empty squares.
  function automatic logic is_piece(input logic [PIECE_WIDTH-1:0] code);
    return (code[2:0] != 3'd0) && (code[2:0] != 3'd7);
  endfunction

  function automatic logic [NSQ-1:0] attack_set(input logic [BW-1:0] b, input logic c,
                                                input logic [IW-1:0] sq);
    logic [PIECE_WIDTH-1:0] code;
    logic [2:0]             pt;
    logic [IW-1:0]          ti;
    logic                   live;
    int                     s, r, f, tr, tf, dr, df;
    attack_set = '0;
    s    = int'(sq);
    code = sq_code(b, s);
    pt   = code[2:0];
    r    = s / SIDE_WIDTH;
    f    = s % SIDE_WIDTH;
    if (code[PIECE_WIDTH-1] == c) begin
      case (pt)
        3'd1: begin
          dr = c ? -1 : 1;
          for (int k = -1; k <= 1; k += 2) begin
            tr = r + dr;
            tf = f + k;
            if (on_board(tr, tf)) begin
              ti = IW'(tr * SIDE_WIDTH + tf);
              attack_set[ti] = 1'b1;
            end
          end
        end
        3'd2, 3'd6: begin
          for (int i = -2; i <= 2; i++) begin
            for (int j = -2; j <= 2; j++) begin
              tr = r + i;
              tf = f + j;
              if (on_board(tr, tf) &&
                  ((pt == 3'd2 && iabs(i) + iabs(j) == 3) ||
                   (pt == 3'd6 && iabs(i) <= 1 && iabs(j) <= 1 && (i != 0 || j != 0)))) begin
                ti = IW'(tr * SIDE_WIDTH + tf);
                attack_set[ti] = 1'b1;
              end
            end
          end
        end
        3'd3, 3'd4, 3'd5: begin
          // Directions 0-3 orthogonal, 4-7 diagonal.
          for (int d = 0; d < 8; d++) begin
            case (d)
              0:       begin dr =  1; df =  0; end
              1:       begin dr = -1; df =  0; end
              2:       begin dr =  0; df =  1; end
              3:       begin dr =  0; df = -1; end
              4:       begin dr =  1; df =  1; end
              5:       begin dr =  1; df = -1; end
              6:       begin dr = -1; df =  1; end
              default: begin dr = -1; df = -1; end
            endcase
            live = (d < 4) ? (pt != 3'd3) : (pt != 3'd4);
            for (int k = 1; k < SIDE_WIDTH; k++) begin
              tr = r + k * dr;
              tf = f + k * df;
              if (live && on_board(tr, tf)) begin
                ti = IW'(tr * SIDE_WIDTH + tf);
                attack_set[ti] = 1'b1;
                // The first occupied square is included, then the ray stops.
                if (is_piece(sq_code(b, tr * SIDE_WIDTH + tf))) live = 1'b0;
              end else begin
                live = 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  state_t         state, nxt;
  logic [BW-1:0]  board_q;
  logic           color_q;
  logic [NSQ-1:0] acc, acc_nxt, cur_att;
  logic [IW-1:0]  cur;
  logic           proc_en, scan_end;

`ifdef ATTACK_SKIP_EN
  logic [NSQ-1:0] mask, own;

  always_comb begin
    own = '0;
    for (int i = 0; i < NSQ; i++) begin
      own[i] = is_piece(sq_code(board, i)) && (sq_code(board, i) >> (PIECE_WIDTH - 1)) == PIECE_WIDTH'(color);
    end
  end

  // Lowest set mask bit wins.
  always_comb begin
    cur = '0;
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (mask[i]) cur = IW'(i);
    end
  end

  assign proc_en  = (mask != '0);
  assign scan_end = (mask == '0);
`else
  logic [IW-1:0] idx;

  assign cur      = idx;
  assign proc_en  = 1'b1;
  assign scan_end = (idx == IW'(NSQ - 1));
`endif

  assign cur_att = attack_set(board_q, color_q, cur);
  assign acc_nxt = acc | (proc_en ? cur_att : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (board_valid) nxt = SCAN;
      SCAN:    if (scan_end) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q  <= '0;
      color_q  <= 1'b0;
      acc      <= '0;
      attacked <= '0;
`ifdef ATTACK_SKIP_EN
      mask     <= '0;
`else
      idx      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (board_valid) begin
          board_q <= board;
          color_q <= color;
          acc     <= '0;
`ifdef ATTACK_SKIP_EN
          mask    <= own;
`else
          idx     <= '0;
`endif
        end
        SCAN: begin
          acc <= acc_nxt;
`ifdef ATTACK_SKIP_EN
          mask <= mask & (mask - 1'b1);
`else
          idx  <= idx + 1'b1;
`endif
          // Loaded on the final scan cycle so it is valid with the DONE strobe.
          if (scan_end) attacked <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign attacked_valid = (state == DONE);
endmodule

// File: tb/tb_attack_map_gen.sv
module tb_attack_map_gen;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] board = '0;
  logic         color = 1'b0;
  logic         board_valid = 1'b0;
  logic         busy;
  logic [63:0]  attacked;
  logic         attacked_valid;

  attack_map_gen dut (
    .clk(clk), .reset(reset), .board(board), .color(color),
    .board_valid(board_valid), .busy(busy), .attacked(attacked),
    .attacked_valid(attacked_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] map;
    int          cap;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cap;
  logic prev_strobe = 1'b0;
  int   qsq[$];
  logic [3:0] back [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] code);
    put = b;
    put[sq*4 +: 4] = code;
  endfunction

  function automatic int exp_lat(input logic [255:0] b, input logic c);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (b[i*4 +: 3] != 3'd0 && b[i*4 +: 3] != 3'd7 && b[i*4+3] == c) n++;
`ifdef ATTACK_SKIP_EN
    return n + 2;
`else
    return 65;
`endif
  endfunction

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (prev_strobe) chk("busy_drop", 64'(busy), 64'd0);
      prev_strobe = attacked_valid;
      if (attacked_valid) begin
        if (q.size() == 0) begin
          chk("spurious_strobe", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_map"}, attacked, e.map);
          chk({e.name, "_lat"}, 64'(cyc - e.cap), 64'(e.lat));
          chk({e.name, "_busy"}, 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic start(input string name, input logic [255:0] b, input logic c,
                       input logic [63:0] m, input bit push);
    exp_t e;
    @(posedge clk); #1;
    board = b; color = c; board_valid = 1'b1;
    cap = cyc;
    if (push) begin
      e.name = name; e.map = m; e.cap = cap; e.lat = exp_lat(b, c);
      q.push_back(e);
    end
    @(posedge clk); #1;
    board_valid = 1'b0;
    @(negedge clk);
    chk({name, "_busy_rise"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic run(input string name, input logic [255:0] b, input logic c, input logic [63:0] m);
    start(name, b, c, m, 1'b1);
    wait_idle(name);
  endtask

  function automatic logic [63:0] sqmask();
    logic [63:0] r = '0;
    foreach (qsq[i]) r |= 64'd1 << qsq[i];
    return r;
  endfunction

  initial begin
    logic [255:0] b, init;
    logic [63:0]  m;

    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    init = '0;
    for (int f = 0; f < 8; f++) begin
      init = put(init, f, back[f]);
      init = put(init, 8 + f, 4'd1);
      init = put(init, 48 + f, 4'd9);
      init = put(init, 56 + f, 4'h8 | back[f]);
    end

    repeat (3) @(negedge clk);
    chk("rst_attacked", attacked, 64'd0);
    chk("rst_valid", 64'(attacked_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    run("empty", '0, 1'b0, 64'h0);
    b = put('0, 0, 4'd4);
    run("rook_a1_w", b, 1'b0, 64'h01010101010101FE);
    run("rook_a1_b", b, 1'b1, 64'h0);
    b = put(b, 16, 4'd9);
    run("rook_block", b, 1'b0, 64'h00000000000101FE);
    run("knight_a1", put('0, 0, 4'd2), 1'b0, 64'h0000000000020400);
    run("pawn_h2", put('0, 15, 4'd1), 1'b0, 64'h0000000000400000);
    run("init_w", init, 1'b0, 64'h0000000000FFFF7E);
    run("bpawn_e5", put('0, 36, 4'd9), 1'b1, 64'h0000000028000000);

    // Queen d4, black blocker f6, illegal code on d6 must not block.
    b = put(put(put('0, 27, 4'd5), 45, 4'd9), 43, 4'd7);
    qsq = '{24, 25, 26, 28, 29, 30, 31, 3, 11, 19, 35, 43, 51, 59,
            36, 45, 18, 9, 0, 34, 41, 48, 20, 13, 6};
    m = sqmask();
    run("queen_d4", b, 1'b0, m);

    b = put(put('0, 63, 4'he), 1, 4'd6);
    qsq = '{62, 54, 55};
    m = sqmask();
    run("bking_h8", b, 1'b1, m);

    // Reset in the middle of a scan: no strobe, outputs cleared.
    start("rst_mid", init, 1'b0, 64'h0, 1'b0);
    while (cyc < cap + 10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_attacked", attacked, 64'd0);
    chk("mid_rst_valid", 64'(attacked_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (80) @(negedge clk);
    run("after_rst", put('0, 0, 4'd4), 1'b0, 64'h01010101010101FE);

    // A second request during SCAN is dropped and the board change has no effect.
    start("ignore", init, 1'b0, 64'h0000000000FFFF7E, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    board = put('0, 0, 4'd4);
    board_valid = 1'b1;
    @(posedge clk); #1;
    board_valid = 1'b0;
    wait_idle("ignore");
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
